// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Transmit-side controller for the node-to-node UART link. Four local
//   requesters share one serial TX line. The winner's destination and payload
//   are packed as {NODE_ID, dest, data} and sent as an 8N1 frame, LSB first.
//   A packet addressed to this node is not transmitted; it is reported with a
//   one-cycle loop_valid pulse instead.
//
//   Build option: define UART_ARB_RR_EN for round-robin arbitration. Without
//   it, arbitration is fixed priority with requester 0 highest.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (2..65535)
//   NODE_ID       this node's identifier, packet bits [7:6]
// Ports
//   clk           clock, rising edge
//   reset         synchronous active-high reset
//   req[3:0]      request level per requester, held until its grant pulses
//   req_dest[7:0] destination, requester i at [2i+1:2i]
//   req_data[15:0] payload, requester i at [4i+3:4i]
//   grant[3:0]    one-hot one-cycle pulse, request latched
//   tx            serial line, idles high
//   busy          high while a frame is in progress
//   last_packet   most recently latched packet
//   loop_valid    one-cycle pulse for a self-addressed packet
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | line high, arbitrating when no grant is pulsing
// START | start bit (tx low) for CLKS_PER_BIT cycles
// DATA  | 8 data bits from shiftReg[0], LSB first
// STOP  | stop bit (tx high) for CLKS_PER_BIT cycles

module uart_tx_arbiter #(
   parameter int         CLKS_PER_BIT = 5208,
   parameter logic [1:0] NODE_ID      = 2'b00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic [7:0]  req_dest,
   input  logic [15:0] req_data,
   output logic [3:0]  grant,
   output logic        tx,
   output logic        busy,
   output logic [7:0]  last_packet,
   output logic        loop_valid
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [15:0] TIMER_LAST = 16'(CLKS_PER_BIT - 1);

   state_t      state, stateNext;
   logic [15:0] timer, timerNext;
   logic [2:0]  bitIdx, bitIdxNext;
   logic [7:0]  shiftReg, shiftNext;
   logic [7:0]  lastNext;
   logic [3:0]  grantNext;
   logic        loopNext;

   logic        winValid;
   logic [1:0]  winIdx;
   logic [1:0]  destSel;
   logic [3:0]  dataSel;
   logic        timerAtEnd;

`ifdef UART_ARB_RR_EN
   logic [1:0] rrPtr, rrPtrNext;
   logic [1:0] cand;

   // Walk from the lowest-priority slot to the highest so the candidate
   // closest after rrPtr is the last one assigned and therefore wins.
   always_comb begin
      winValid = 1'b0;
      winIdx   = rrPtr;
      cand     = rrPtr;
      for (int i = 4; i >= 1; i--) begin
         cand = rrPtr + 2'(i);
         if (req[cand]) begin
            winValid = 1'b1;
            winIdx   = cand;
         end
      end
   end
`else
   always_comb begin
      winValid = 1'b0;
      winIdx   = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (req[i]) begin
            winValid = 1'b1;
            winIdx   = 2'(i);
         end
      end
   end
`endif

   assign destSel    = req_dest[{winIdx, 1'b0} +: 2];
   assign dataSel    = req_data[{winIdx, 2'b00} +: 4];
   assign timerAtEnd = (timer == TIMER_LAST);

   always_comb begin
      stateNext  = state;
      timerNext  = timer;
      bitIdxNext = bitIdx;
      shiftNext  = shiftReg;
      lastNext   = last_packet;
      grantNext  = 4'b0000;
      loopNext   = 1'b0;
`ifdef UART_ARB_RR_EN
      rrPtrNext  = rrPtr;
`endif
      tx         = 1'b1;
      busy       = (state != IDLE);

      case (state)
         IDLE: begin
            timerNext  = 16'd0;
            bitIdxNext = 3'd0;
            // While a grant is pulsing the requester has not yet had a chance
            // to drop req, so that cycle must not arbitrate again.
            if (winValid && (grant == 4'b0000)) begin
               grantNext = 4'b0001 << winIdx;
               lastNext  = {NODE_ID, destSel, dataSel};
               shiftNext = {NODE_ID, destSel, dataSel};
`ifdef UART_ARB_RR_EN
               rrPtrNext = winIdx;
`endif
               if (destSel == NODE_ID)
                  loopNext = 1'b1;
               else
                  stateNext = START;
            end
         end
         START: begin
            tx        = 1'b0;
            timerNext = timerAtEnd ? 16'd0 : timer + 16'd1;
            if (timerAtEnd)
               stateNext = DATA;
         end
         DATA: begin
            tx        = shiftReg[0];
            timerNext = timerAtEnd ? 16'd0 : timer + 16'd1;
            if (timerAtEnd) begin
               shiftNext  = shiftReg >> 1;
               bitIdxNext = bitIdx + 3'd1;
               if (bitIdx == 3'd7)
                  stateNext = STOP;
            end
         end
         STOP: begin
            timerNext = timerAtEnd ? 16'd0 : timer + 16'd1;
            if (timerAtEnd)
               stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         timer       <= 16'd0;
         bitIdx      <= 3'd0;
         shiftReg    <= 8'h00;
         last_packet <= 8'h00;
         grant       <= 4'b0000;
         loop_valid  <= 1'b0;
`ifdef UART_ARB_RR_EN
         rrPtr       <= 2'd3;
`endif
      end else begin
         state       <= stateNext;
         timer       <= timerNext;
         bitIdx      <= bitIdxNext;
         shiftReg    <= shiftNext;
         last_packet <= lastNext;
         grant       <= grantNext;
         loop_valid  <= loopNext;
`ifdef UART_ARB_RR_EN
         rrPtr       <= rrPtrNext;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: a transaction-level model predicts the
// winner, packet, loopback and the full serial waveform for each arbitration.
module tb_uart_tx_arbiter;

   localparam int         CPB  = 4;
   localparam logic [1:0] NODE = 2'b01;

   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic [7:0]  reqDest;
   logic [15:0] reqData;
   logic [3:0]  grant;
   logic        tx;
   logic        busy;
   logic [7:0]  lastPacket;
   logic        loopValid;

   logic [3:0]  req2;
   logic [7:0]  reqDest2;
   logic [15:0] reqData2;
   logic [3:0]  grant2;
   logic        tx2;
   logic        busy2;
   logic [7:0]  lastPacket2;
   logic        loopValid2;

   int          nChecks = 0;
   int          nFails  = 0;
   logic [3:0]  holdMask;
   logic [3:0]  lateMask;
`ifdef UART_ARB_RR_EN
   logic [1:0]  modelPtr;
`endif

   uart_tx_arbiter #(.CLKS_PER_BIT(CPB), .NODE_ID(NODE)) dut (
      .clk(clk), .reset(reset), .req(req), .req_dest(reqDest),
      .req_data(reqData), .grant(grant), .tx(tx), .busy(busy),
      .last_packet(lastPacket), .loop_valid(loopValid)
   );

   uart_tx_arbiter #(.CLKS_PER_BIT(2), .NODE_ID(NODE)) dut2 (
      .clk(clk), .reset(reset), .req(req2), .req_dest(reqDest2),
      .req_data(reqData2), .grant(grant2), .tx(tx2), .busy(busy2),
      .last_packet(lastPacket2), .loop_valid(loopValid2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Index of the requester the arbitration rule picks, or -1 if none.
   function automatic int pickWinner(input logic [3:0] r);
      int start;
`ifdef UART_ARB_RR_EN
      start = int'(modelPtr) + 1;
`else
      start = 0;
`endif
      for (int i = 0; i < 4; i++)
         if (r[(start + i) % 4]) return (start + i) % 4;
      return -1;
   endfunction

   // Called at a negedge where the DUT is idle with no grant pulsing; returns
   // at the next such point.
   task automatic arbStep();
      int         w;
      logic [1:0] d;
      logic [3:0] dt;
      logic [7:0] pkt;
      logic [9:0] frame;
      w  = pickWinner(req);
      d  = 2'b00;
      dt = 4'h0;
      if (w >= 0) begin
         d  = reqDest[2*w +: 2];
         dt = reqData[4*w +: 4];
      end
      @(negedge clk);
      if (w < 0) begin
         checkVal("idleGrant", grant, 0);
         checkVal("idleBusy", busy, 0);
         checkVal("idleTx", tx, 1);
         return;
      end
      pkt = {NODE, d, dt};
      checkVal("grant", grant, 32'(4'b0001 << w));
      checkVal("lastPacket", lastPacket, pkt);
      checkVal("loopValid", loopValid, (d == NODE));
`ifdef UART_ARB_RR_EN
      modelPtr = 2'(w);
`endif
      req[w] = holdMask[w];
      if (d == NODE) begin
         checkVal("loopTx", tx, 1);
         checkVal("loopBusy", busy, 0);
         @(negedge clk);
         checkVal("postLoopGrant", grant, 0);
         checkVal("postLoopValid", loopValid, 0);
         return;
      end
      frame = {1'b1, pkt, 1'b0};
      for (int k = 0; k < 10*CPB; k++) begin
         checkVal("txBit", tx, frame[k/CPB]);
         checkVal("frameBusy", busy, 1);
         if (k > 0) checkVal("frameGrant", grant, 0);
         if (k == 5*CPB) req = req | lateMask;
         @(negedge clk);
      end
      checkVal("gapTx", tx, 1);
      checkVal("gapBusy", busy, 0);
   endtask

   initial begin
      int         n;
      logic [9:0] frame2;
      reset = 1'b1;
      req = 0; reqDest = 0; reqData = 0;
      req2 = 0; reqDest2 = 0; reqData2 = 0;
      holdMask = 0; lateMask = 0;
`ifdef UART_ARB_RR_EN
      modelPtr = 2'd3;
`endif
      repeat (3) @(negedge clk);
      checkVal("rstTx", tx, 1);
      checkVal("rstBusy", busy, 0);
      checkVal("rstGrant", grant, 0);
      checkVal("rstLoop", loopValid, 0);
      checkVal("rstLast", lastPacket, 8'h00);
      reset = 1'b0;

      // contention, all held, destination 00
      reqDest = 8'h00; reqData = 16'h4321;
      req = 4'b1011; holdMask = 4'b1011;
      repeat (4) arbStep();
      holdMask = 0; req = 0;
      arbStep();

      // single request, packet 6A
      reqDest[1:0] = 2'b10; reqData[3:0] = 4'hA; req = 4'b0001;
      arbStep();

      // loopback from requester 2, packet 53
      reqDest[5:4] = 2'b01; reqData[11:8] = 4'h3; req = 4'b0100;
      arbStep();

      // late request from requester 3 during requester 0's data phase
      reqDest[1:0] = 2'b10; reqData[3:0] = 4'h5; req = 4'b0001;
      reqDest[7:6] = 2'b11; reqData[15:12] = 4'hC; lateMask = 4'b1000;
      arbStep();
      lateMask = 0;
      arbStep();

      // reset during data bit 4 with requester 2 pending
      reqDest[1:0] = 2'b11; reqData[3:0] = 4'h9; req = 4'b0001;
      @(negedge clk);
      checkVal("rstFrameGrant", grant, 4'b0001);
      req[0] = 1'b0;
      reqDest[5:4] = 2'b00; reqData[11:8] = 4'h7; req[2] = 1'b1;
      repeat (5*CPB) @(negedge clk);
      checkVal("preRstBusy", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      checkVal("midRstTx", tx, 1);
      checkVal("midRstBusy", busy, 0);
      checkVal("midRstGrant", grant, 0);
      checkVal("midRstLast", lastPacket, 8'h00);
      reset = 1'b0;
`ifdef UART_ARB_RR_EN
      modelPtr = 2'd3;
`endif
      arbStep();

      // two clocks per bit on the second instance
      reqDest2[1:0] = 2'b00; reqData2[3:0] = 4'h6; req2 = 4'b0001;
      @(negedge clk);
      checkVal("t2Grant", grant2, 4'b0001);
      req2 = 0;
      frame2 = {1'b1, NODE, 2'b00, 4'h6, 1'b0};
      n = 0;
      while (busy2 && n < 100) begin
         if (n < 20) checkVal("t2Bit", tx2, frame2[n/2]);
         n++;
         @(negedge clk);
      end
      checkVal("t2Len", n, 20);
      checkVal("t2IdleTx", tx2, 1);

      // randomized traffic
      repeat (40) begin
         for (int i = 0; i < 4; i++) begin
            if (!req[i] && ($urandom % 2 == 1)) begin
               reqDest[2*i +: 2] = 2'($urandom);
               reqData[4*i +: 4] = 4'($urandom);
               req[i] = 1'b1;
            end
         end
         arbStep();
      end
      req = 0;
      arbStep();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
